// File: rtl/pack_stage_arbiter.sv
// ---------------------------------------------------------------------------
// pack_stage_arbiter
//
// Two-requester front end for the pack stage. Each requester (A, B) owns a
// one-entry holding buffer. Full buffers are granted round-robin whenever
// the downstream is not stalled. The granted operand set is registered
// onto the pack-stage outputs. A short source pipeline tracks which
// requester owns each in-flight set, so the pack stage's done_in can be
// routed back as resp_done_a / resp_done_b.
//
// Ports
//   clock, reset                  clock and asynchronous active-high reset
//   req_valid_x / req_ready_x     offer handshake per requester (x = a, b)
//   req_idle_x, req_zout_x,       operand set offered by requester x
//   req_product_x, req_tag_x,
//   req_z_x
//   stall                         downstream stall; no issue while high
//   idle_out, zout_out,           registered operand set to the pack stage
//   productout_out, InsTag_out,
//   z_out, ScaleValid_out
//   done_in                       pack stage done, PACK_LATENCY after issue
//   resp_done_x                   one-cycle completion pulse to requester x
//   issue_count_x                 wrapping 16-bit count of issues per requester
//   err_unexpected_done           sticky done/pipeline disagreement flag
// ---------------------------------------------------------------------------
module pack_stage_arbiter #(
  parameter int PACK_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        req_valid_a,
  output logic        req_ready_a,
  input  logic        req_idle_a,
  input  logic [32:0] req_zout_a,
  input  logic [49:0] req_product_a,
  input  logic [7:0]  req_tag_a,
  input  logic [31:0] req_z_a,

  input  logic        req_valid_b,
  output logic        req_ready_b,
  input  logic        req_idle_b,
  input  logic [32:0] req_zout_b,
  input  logic [49:0] req_product_b,
  input  logic [7:0]  req_tag_b,
  input  logic [31:0] req_z_b,

  input  logic        stall,

  output logic        idle_out,
  output logic [32:0] zout_out,
  output logic [49:0] productout_out,
  output logic [7:0]  InsTag_out,
  output logic [31:0] z_out,
  output logic        ScaleValid_out,

  input  logic        done_in,
  output logic        resp_done_a,
  output logic        resp_done_b,
  output logic [15:0] issue_count_a,
  output logic [15:0] issue_count_b,
  output logic        err_unexpected_done
);

  typedef struct packed {
    logic        idle;
    logic [32:0] zout;
    logic [49:0] product;
    logic [7:0]  tag;
    logic [31:0] z;
  } opset_t;

  // Idle output with cleared data fields.
  localparam opset_t OUT_RESET = opset_t'{1'b1, 33'd0, 50'd0, 8'd0, 32'd0};

  // Source encoding used by last_grant and the source pipeline.
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // -------------------------------------------------------------------------
  // Requester-indexed views of the offer ports (index 0 = A, 1 = B).
  // -------------------------------------------------------------------------
  logic [1:0] offer_valid;
  opset_t     offer [2];

  assign offer_valid[0] = req_valid_a;
  assign offer_valid[1] = req_valid_b;
  assign offer[0] = opset_t'{req_idle_a, req_zout_a, req_product_a, req_tag_a, req_z_a};
  assign offer[1] = opset_t'{req_idle_b, req_zout_b, req_product_b, req_tag_b, req_z_b};

  // -------------------------------------------------------------------------
  // Grant selection.
  // With both buffers full the requester not granted last wins; with one
  // full it wins regardless of last_grant. Nothing is granted under stall.
  // -------------------------------------------------------------------------
  logic [1:0] full_reg;
  opset_t     buf_reg [2];
  logic [1:0] grant;
  logic [1:0] ready;
  logic [1:0] accept;
  logic       last_grant_reg;

  always_comb begin
    grant = 2'b00;
    if (!stall) begin
      if (full_reg == 2'b11) begin
        grant = (last_grant_reg == SRC_B) ? 2'b01 : 2'b10;
      end else begin
        grant = full_reg;
      end
    end
  end

  // A buffer being drained this cycle can take a new offer at the same edge,
  // which is what lets a single requester stream at one issue per cycle.
  assign ready  = ~full_reg | grant;
  assign accept = offer_valid & ready;

  assign req_ready_a = ready[0];
  assign req_ready_b = ready[1];

  // -------------------------------------------------------------------------
  // Holding buffers, one per requester.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      logic   full_r;
      opset_t data_r;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          full_r <= 1'b0;
          data_r <= '0;
        end else if (accept[gi]) begin
          // A new offer replaces a set that is leaving this edge.
          full_r <= 1'b1;
          data_r <= offer[gi];
        end else if (grant[gi]) begin
          full_r <= 1'b0;
        end
      end

      assign full_reg[gi] = full_r;
      assign buf_reg[gi]  = data_r;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Issue registers, round-robin state and per-requester issue counters.
  // -------------------------------------------------------------------------
  logic       any_grant;
  logic       issue_src;
  opset_t     issue_set;
  opset_t     out_reg;
  logic       scale_valid_reg;
  logic       out_src_reg;
  logic [15:0] count_a_reg;
  logic [15:0] count_b_reg;

  assign any_grant = |grant;
  assign issue_src = grant[1] ? SRC_B : SRC_A;
  assign issue_set = grant[1] ? buf_reg[1] : buf_reg[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_reg         <= OUT_RESET;
      scale_valid_reg <= 1'b0;
      out_src_reg     <= SRC_A;
      last_grant_reg  <= SRC_B;
      count_a_reg     <= 16'd0;
      count_b_reg     <= 16'd0;
    end else if (any_grant) begin
      out_reg         <= issue_set;
      scale_valid_reg <= 1'b1;
      out_src_reg     <= issue_src;
      last_grant_reg  <= issue_src;
      if (issue_src == SRC_A) begin
        count_a_reg <= count_a_reg + 16'd1;
      end else begin
        count_b_reg <= count_b_reg + 16'd1;
      end
    end else begin
      // Bubble: data fields hold their last issued values.
      scale_valid_reg <= 1'b0;
      out_reg.idle    <= 1'b1;
    end
  end

  assign idle_out       = out_reg.idle;
  assign zout_out       = out_reg.zout;
  assign productout_out = out_reg.product;
  assign InsTag_out     = out_reg.tag;
  assign z_out          = out_reg.z;
  assign ScaleValid_out = scale_valid_reg;
  assign issue_count_a  = count_a_reg;
  assign issue_count_b  = count_b_reg;

  // -------------------------------------------------------------------------
  // Source pipeline. It shifts every cycle, stall or not, because the pack
  // stage's done timing is fixed relative to ScaleValid_out. The last stage
  // lines up with the cycle done_in is expected for that set.
  // -------------------------------------------------------------------------
  logic [PACK_LATENCY-1:0] pipe_valid_reg;
  logic [PACK_LATENCY-1:0] pipe_src_reg;
  logic [PACK_LATENCY-1:0] pipe_valid_next;
  logic [PACK_LATENCY-1:0] pipe_src_next;

  generate
    for (genvar gi = 0; gi < PACK_LATENCY; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign pipe_valid_next[gi] = scale_valid_reg;
        assign pipe_src_next[gi]   = out_src_reg;
      end else begin : g_body
        assign pipe_valid_next[gi] = pipe_valid_reg[gi-1];
        assign pipe_src_next[gi]   = pipe_src_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pipe_valid_reg <= '0;
      pipe_src_reg   <= '0;
    end else begin
      pipe_valid_reg <= pipe_valid_next;
      pipe_src_reg   <= pipe_src_next;
    end
  end

  // -------------------------------------------------------------------------
  // Completion routing. A done with nothing due, or a due set without its
  // done, is an error. In the second case the completion is dropped.
  // -------------------------------------------------------------------------
  logic last_valid;
  logic last_src;
  logic resp_a_reg;
  logic resp_b_reg;
  logic err_reg;

  assign last_valid = pipe_valid_reg[PACK_LATENCY-1];
  assign last_src   = pipe_src_reg[PACK_LATENCY-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_a_reg <= 1'b0;
      resp_b_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      resp_a_reg <= done_in & last_valid & (last_src == SRC_A);
      resp_b_reg <= done_in & last_valid & (last_src == SRC_B);
      if (done_in ^ last_valid) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign resp_done_a         = resp_a_reg;
  assign resp_done_b         = resp_b_reg;
  assign err_unexpected_done = err_reg;

endmodule

// File: tb/tb_pack_stage_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pack_stage_arbiter
//
// Drives the arbiter with directed scenarios and then randomized traffic.
// Every cycle it compares all outputs against a transaction-level model.
// The model keeps each requester's pending set, picks the issue winner from
// the arbitration rules, and keeps a queue of issued sets stamped with the
// cycle their done is due.
// ---------------------------------------------------------------------------
module tb_pack_stage_arbiter;

  localparam int L = 2;

  typedef struct packed {
    logic        idle;
    logic [32:0] zout;
    logic [49:0] product;
    logic [7:0]  tag;
    logic [31:0] z;
  } opset_t;

  typedef struct {
    int e;
    bit src;
  } flight_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic        req_valid_a, req_ready_a, req_idle_a;
  logic [32:0] req_zout_a;
  logic [49:0] req_product_a;
  logic [7:0]  req_tag_a;
  logic [31:0] req_z_a;
  logic        req_valid_b, req_ready_b, req_idle_b;
  logic [32:0] req_zout_b;
  logic [49:0] req_product_b;
  logic [7:0]  req_tag_b;
  logic [31:0] req_z_b;
  logic        stall;
  logic        idle_out;
  logic [32:0] zout_out;
  logic [49:0] productout_out;
  logic [7:0]  InsTag_out;
  logic [31:0] z_out;
  logic        ScaleValid_out;
  logic        done_in;
  logic        resp_done_a, resp_done_b;
  logic [15:0] issue_count_a, issue_count_b;
  logic        err_unexpected_done;

  bit     drv_v [2];
  opset_t drv   [2];

  assign req_valid_a   = drv_v[0];
  assign req_idle_a    = drv[0].idle;
  assign req_zout_a    = drv[0].zout;
  assign req_product_a = drv[0].product;
  assign req_tag_a     = drv[0].tag;
  assign req_z_a       = drv[0].z;
  assign req_valid_b   = drv_v[1];
  assign req_idle_b    = drv[1].idle;
  assign req_zout_b    = drv[1].zout;
  assign req_product_b = drv[1].product;
  assign req_tag_b     = drv[1].tag;
  assign req_z_b       = drv[1].z;

  pack_stage_arbiter #(.PACK_LATENCY(L)) dut (
    .clock(clock), .reset(reset),
    .req_valid_a(req_valid_a), .req_ready_a(req_ready_a), .req_idle_a(req_idle_a),
    .req_zout_a(req_zout_a), .req_product_a(req_product_a), .req_tag_a(req_tag_a),
    .req_z_a(req_z_a),
    .req_valid_b(req_valid_b), .req_ready_b(req_ready_b), .req_idle_b(req_idle_b),
    .req_zout_b(req_zout_b), .req_product_b(req_product_b), .req_tag_b(req_tag_b),
    .req_z_b(req_z_b),
    .stall(stall),
    .idle_out(idle_out), .zout_out(zout_out), .productout_out(productout_out),
    .InsTag_out(InsTag_out), .z_out(z_out), .ScaleValid_out(ScaleValid_out),
    .done_in(done_in), .resp_done_a(resp_done_a), .resp_done_b(resp_done_b),
    .issue_count_a(issue_count_a), .issue_count_b(issue_count_b),
    .err_unexpected_done(err_unexpected_done)
  );

  always #5 clock = ~clock;

  // ---------------- model state ----------------
  bit        m_full [2];
  opset_t    m_buf  [2];
  bit        m_last_b;
  opset_t    m_out;
  bit        m_sv;
  bit [15:0] m_cnt  [2];
  bit        m_resp [2];
  bit        m_err;
  flight_t   m_q [$];
  int        ecnt;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, ecnt);
    end
  endtask

  // Which requester issues at the next edge, -1 for none.
  function automatic int winner(input bit st);
    if (st) return -1;
    if (m_full[0] && m_full[1]) return m_last_b ? 0 : 1;
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  // The pack stage's correct done for the current cycle.
  function automatic bit due_now();
    return (m_q.size() > 0) && (m_q[0].e + L == ecnt);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 0; m_buf[i] = '0; m_cnt[i] = '0; m_resp[i] = 0;
    end
    m_last_b = 1;
    m_out = '0;
    m_out.idle = 1'b1;
    m_sv = 0;
    m_err = 0;
    m_q.delete();
  endtask

  task automatic model_edge();
    int w;
    bit acc [2];
    flight_t f;
    w = winner(stall);
    for (int i = 0; i < 2; i++) acc[i] = drv_v[i] && (!m_full[i] || w == i);
    m_resp[0] = 0;
    m_resp[1] = 0;
    if (due_now()) begin
      f = m_q.pop_front();
      if (done_in) m_resp[f.src] = 1;
      else m_err = 1;
    end else if (done_in) begin
      m_err = 1;
    end
    if (w >= 0) begin
      m_out = m_buf[w];
      m_sv = 1;
      m_cnt[w] = m_cnt[w] + 16'd1;
      m_last_b = (w == 1);
      f.e = ecnt + 1;
      f.src = (w == 1);
      m_q.push_back(f);
    end else begin
      m_sv = 0;
      m_out.idle = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        m_full[i] = 1;
        m_buf[i] = drv[i];
      end else if (w == i) begin
        m_full[i] = 0;
      end
    end
    ecnt++;
  endtask

  task automatic check_all();
    int w;
    w = winner(stall);
    check_eq("ready_a", 64'(req_ready_a), 64'(!m_full[0] || w == 0));
    check_eq("ready_b", 64'(req_ready_b), 64'(!m_full[1] || w == 1));
    check_eq("scale_valid", 64'(ScaleValid_out), 64'(m_sv));
    check_eq("idle_out", 64'(idle_out), 64'(m_out.idle));
    check_eq("zout_out", 64'(zout_out), 64'(m_out.zout));
    check_eq("productout", 64'(productout_out), 64'(m_out.product));
    check_eq("ins_tag", 64'(InsTag_out), 64'(m_out.tag));
    check_eq("z_out", 64'(z_out), 64'(m_out.z));
    check_eq("resp_done_a", 64'(resp_done_a), 64'(m_resp[0]));
    check_eq("resp_done_b", 64'(resp_done_b), 64'(m_resp[1]));
    check_eq("issue_count_a", 64'(issue_count_a), 64'(m_cnt[0]));
    check_eq("issue_count_b", 64'(issue_count_b), 64'(m_cnt[1]));
    check_eq("err_unexp", 64'(err_unexpected_done), 64'(m_err));
  endtask

  function automatic opset_t rand_set(input logic [7:0] tag);
    opset_t s;
    s.idle    = 1'($urandom);
    s.zout    = {1'($urandom), 32'($urandom)};
    s.product = {18'($urandom), 32'($urandom)};
    s.tag     = tag;
    s.z       = 32'($urandom);
    return s;
  endfunction

  // One clock: drive at posedge+1, check at negedge, advance model at posedge.
  task automatic run_cycle(input bit va, input bit vb, input bit st, input bit dn,
                           input logic [7:0] ta, input logic [7:0] tb_tag);
    drv_v[0] = va;
    drv_v[1] = vb;
    drv[0] = rand_set(ta);
    drv[1] = rand_set(tb_tag);
    stall = st;
    done_in = dn;
    @(negedge clock);
    check_all();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  // Asserted mid-cycle; outputs are checked before any clock edge.
  task automatic apply_reset();
    drv_v[0] = 0;
    drv_v[1] = 0;
    stall = 0;
    done_in = 0;
    reset = 1'b1;
    #2;
    model_reset();
    check_all();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    ecnt = 0;
    drv_v[0] = 0; drv_v[1] = 0;
    drv[0] = '0; drv[1] = '0;
    stall = 0; done_in = 0;
    model_reset();
    #1;
    apply_reset();

    // Single requester A, tag 0x05, correct done.
    run_cycle(1, 0, 0, due_now(), 8'h05, 8'h00);
    for (int i = 0; i < L + 4; i++) run_cycle(0, 0, 0, due_now(), 8'h00, 8'h00);
    check_eq("single_count_a", 64'(issue_count_a), 64'd1);

    // Contention: both offer continuously after reset.
    apply_reset();
    for (int i = 0; i < 8; i++) run_cycle(1, 1, 0, due_now(), 8'h10, 8'h20);
    for (int i = 0; i < L + 4; i++) run_cycle(0, 0, 0, due_now(), 8'h00, 8'h00);

    // Stall with both buffers full, then release.
    apply_reset();
    run_cycle(1, 1, 1, 0, 8'h31, 8'h32);
    for (int i = 0; i < 3; i++) run_cycle(1, 1, 1, due_now(), 8'h41, 8'h42);
    for (int i = 0; i < L + 4; i++) run_cycle(0, 0, 0, due_now(), 8'h00, 8'h00);

    // Unexpected done with nothing in flight.
    apply_reset();
    run_cycle(0, 0, 0, 1, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) run_cycle(0, 0, 0, 0, 8'h00, 8'h00);
    check_eq("err_sticky", 64'(err_unexpected_done), 64'd1);

    // Reset one cycle after issue; the late done must become an error.
    apply_reset();
    run_cycle(1, 0, 0, 0, 8'h55, 8'h00);
    run_cycle(0, 0, 0, 0, 8'h00, 8'h00);
    apply_reset();
    for (int i = 0; i < L + 2; i++) run_cycle(0, 0, 0, 1, 8'h00, 8'h00);

    // Randomized traffic with occasional bad dones and resets.
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        apply_reset();
      end else begin
        run_cycle(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                  due_now() ^ ($urandom_range(0, 19) == 0),
                  8'($urandom), 8'($urandom));
      end
    end

    // Counter wrap: A streams 65536 issues.
    apply_reset();
    for (int i = 0; i < 65537; i++) run_cycle(1, 0, 0, due_now(), 8'($urandom), 8'h00);
    @(negedge clock);
    check_eq("wrap_count_a", 64'(issue_count_a), 64'd0);
    @(posedge clock);
    model_edge();
    #1;
    for (int i = 0; i < L + 3; i++) run_cycle(0, 0, 0, due_now(), 8'h00, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
